// File: rtl/selftrigger_peak_detector.sv
// selftrigger_peak_detector: confirmed threshold trigger with peak tracking, hysteresis end, width limit and holdoff
module selftrigger_peak_detector #(
  parameter int CONFIRM     = 3,
  parameter int HYST        = 16,
  parameter int MAX_WIDTH   = 1024,
  parameter int HOLDOFF_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] x,
  input  logic [15:0] threshold,
  output logic        trigger,
  output logic        peak_valid,
  output logic [15:0] peak_value,
  output logic        truncated,
  output logic        busy,
  output logic [15:0] trig_count
);
  localparam int M1 = MAX_WIDTH > HOLDOFF_LEN ? MAX_WIDTH : HOLDOFF_LEN;
  localparam int CW = $clog2((M1 > 16 ? M1 : 16) + 1);
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, HOLDOFF} state_t;
  state_t             r_state;
  logic [15:0]        r_x_prev, r_peak, r_peak_value, r_trig_count;
  logic [CW-1:0]      r_cnt;
  logic               r_trigger, r_peak_valid, r_truncated, r_busy;
  logic signed [16:0] w_lo17;
  logic [15:0]        w_lo, w_max;
  logic               w_above, w_cross, w_below;
  logic [CW-1:0]      w_cnt_n;
  // low level is widened to 17 bits so a very negative threshold saturates instead of wrapping
  assign w_lo17  = $signed({threshold[15], threshold}) - $signed(17'(HYST));
  assign w_lo    = (w_lo17 < -17'sd32768) ? 16'h8000 : w_lo17[15:0];
  assign w_above = $signed(x) > $signed(threshold);
  assign w_cross = w_above && !($signed(r_x_prev) > $signed(threshold));
  assign w_below = $signed(x) < $signed(w_lo);
  assign w_max   = ($signed(x) > $signed(r_peak)) ? x : r_peak;
  assign w_cnt_n = r_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_x_prev     <= 16'h7FFF;
      r_peak       <= '0;
      r_cnt        <= '0;
      r_trigger    <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_value <= '0;
      r_truncated  <= 1'b0;
      r_busy       <= 1'b0;
      r_trig_count <= '0;
    end else if (clear) begin
      r_state      <= IDLE;
      r_x_prev     <= 16'h7FFF;
      r_peak       <= '0;
      r_cnt        <= '0;
      r_trigger    <= 1'b0;
      r_peak_valid <= 1'b0;
      r_truncated  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_trigger    <= 1'b0;
      r_peak_valid <= 1'b0;
      if (enable) begin
        r_x_prev <= x;
        case (r_state)
          IDLE: if (w_cross) begin
            r_peak <= x;
            r_busy <= 1'b1;
            if (CONFIRM == 1) begin
              r_state      <= ACTIVE;
              r_cnt        <= '0;
              r_trigger    <= 1'b1;
              r_trig_count <= r_trig_count + 1'b1;
            end else begin
              r_state <= ARMING;
              r_cnt   <= CW'(1);
            end
          end
          ARMING: if (w_above) begin
            r_peak <= w_max;
            if (w_cnt_n == CW'(CONFIRM)) begin
              r_state      <= ACTIVE;
              r_cnt        <= '0;
              r_trigger    <= 1'b1;
              r_trig_count <= r_trig_count + 1'b1;
            end else r_cnt <= w_cnt_n;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          ACTIVE: if (w_below) begin
            r_state      <= HOLDOFF;
            r_cnt        <= '0;
            r_peak_valid <= 1'b1;
            r_peak_value <= r_peak;
            r_truncated  <= 1'b0;
          end else if (w_cnt_n == CW'(MAX_WIDTH)) begin
            r_state      <= HOLDOFF;
            r_cnt        <= '0;
            r_peak_valid <= 1'b1;
            r_peak_value <= w_max;
            r_truncated  <= 1'b1;
          end else begin
            r_peak <= w_max;
            r_cnt  <= w_cnt_n;
          end
          default: if (w_cnt_n == CW'(HOLDOFF_LEN)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else r_cnt <= w_cnt_n;
        endcase
      end
    end
  end
  assign trigger    = r_trigger;
  assign peak_valid = r_peak_valid;
  assign peak_value = r_peak_value;
  assign truncated  = r_truncated;
  assign busy       = r_busy;
  assign trig_count = r_trig_count;
endmodule

// File: tb/tb_selftrigger_peak_detector.sv
// tb_selftrigger_peak_detector: scoreboard of expected trigger/peak events keyed by accepting clock edge
module tb_selftrigger_peak_detector;
  typedef struct packed { int e; logic k; logic [15:0] v; logic t; } ev_t;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [15:0] x = '0, threshold = 16'd100;
  logic        trigger, peak_valid, truncated, busy;
  logic [15:0] peak_value, trig_count;
  int          n_pass = 0, n_total = 0, edge_n = 0;
  logic [15:0] exp_tc = '0;
  ev_t         exp_q[$], obs_q[$];

  selftrigger_peak_detector #(.CONFIRM(3), .HYST(16), .MAX_WIDTH(16), .HOLDOFF_LEN(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .x(x), .threshold(threshold),
    .trigger(trigger), .peak_valid(peak_valid), .peak_value(peak_value), .truncated(truncated),
    .busy(busy), .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] xv, input logic en);
    x = xv;
    enable = en;
    @(posedge clk);
    #1;
    edge_n++;
    if (trigger) obs_q.push_back('{edge_n, 1'b0, trig_count, 1'b0});
    if (peak_valid) obs_q.push_back('{edge_n, 1'b1, peak_value, truncated});
  endtask

  function automatic void exp_trig(input int e);
    exp_tc = exp_tc + 16'd1;
    exp_q.push_back('{e, 1'b0, exp_tc, 1'b0});
  endfunction

  function automatic void exp_pv(input int e, input logic [15:0] v, input logic t);
    exp_q.push_back('{e, 1'b1, v, t});
  endfunction

  task automatic test_reset;
    ev_t e, o;
    reset = 1'b0;
    drive(16'd500, 1'b1);
    drive(16'd500, 1'b1);
    n_total += 6;
    if (trigger !== 1'b0) $display("FAIL reset_trigger: got %b want 0", trigger); else n_pass++;
    if (peak_valid !== 1'b0) $display("FAIL reset_peak_valid: got %b want 0", peak_valid); else n_pass++;
    if (peak_value !== 16'd0) $display("FAIL reset_peak_value: got %0d want 0", peak_value); else n_pass++;
    if (truncated !== 1'b0) $display("FAIL reset_truncated: got %b want 0", truncated); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    if (trig_count !== 16'd0) $display("FAIL reset_trig_count: got %0d want 0", trig_count); else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(16'd500, 1'b1);
    n_total += 2;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    if (trig_count !== 16'd0) $display("FAIL idle_trig_count: got %0d want 0", trig_count); else n_pass++;
    n_total++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL idle_events: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL idle_ev: got e=%0d k=%b v=%0d t=%b want e=%0d k=%b v=%0d t=%b", o.e, o.k, o.v, o.t, e.e, e.k, e.v, e.t); else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_pulse(input bit gap);
    ev_t e, o;
    logic [15:0] s[16] = '{16'd0, 16'd150, 16'd200, 16'd300, 16'd250, 16'd90, 16'd80, 16'd70,
                           16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    int b = edge_n, st = gap ? 2 : 1;
    exp_trig(b + 3 * st + 1);
    exp_pv(b + 6 * st + 1, 16'd300, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(s[i], 1'b1);
      if (gap) drive(16'h7000, 1'b0);
    end
    n_total++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL pulse_events gap=%0d: got %0d want %0d", gap, obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL pulse_ev gap=%0d: got e=%0d k=%b v=%0d t=%b want e=%0d k=%b v=%0d t=%b", gap, o.e, o.k, o.v, o.t, e.e, e.k, e.v, e.t); else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_glitch;
    ev_t e, o;
    logic [15:0] s[6] = '{16'd0, 16'd150, 16'd200, 16'd50, 16'd0, 16'd0};
    for (int i = 0; i < 6; i++) begin
      drive(s[i], 1'b1);
      if (i == 2) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL glitch_arming_busy: got %b want 1", busy); else n_pass++;
      end
    end
    n_total += 2;
    if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else n_pass++;
    if (trig_count !== exp_tc) $display("FAIL glitch_trig_count: got %0d want %0d", trig_count, exp_tc); else n_pass++;
    n_total++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL glitch_events: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL glitch_ev: got e=%0d k=%b v=%0d t=%b want e=%0d k=%b v=%0d t=%b", o.e, o.k, o.v, o.t, e.e, e.k, e.v, e.t); else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_truncation;
    ev_t e, o;
    int b = edge_n;
    exp_trig(b + 4);
    exp_pv(b + 20, 16'd400, 1'b1);
    exp_trig(b + 35);
    exp_pv(b + 36, 16'd400, 1'b0);
    for (int i = 0; i < 45; i++) begin
      drive(((i >= 1 && i <= 30) || (i >= 32 && i <= 34)) ? 16'd400 : 16'd0, 1'b1);
      if (i == 30) begin
        n_total++;
        if (busy !== 1'b0) $display("FAIL trunc_idle_busy: got %b want 0", busy); else n_pass++;
      end
    end
    n_total++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL trunc_events: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL trunc_ev: got e=%0d k=%b v=%0d t=%b want e=%0d k=%b v=%0d t=%b", o.e, o.k, o.v, o.t, e.e, e.k, e.v, e.t); else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_abort;
    ev_t e, o;
    logic [15:0] s[7] = '{16'd250, 16'd250, 16'd0, 16'd150, 16'd200, 16'd300, 16'd250};
    int b = edge_n;
    exp_trig(b + 4);
    drive(16'd0, 1'b1);
    drive(16'd150, 1'b1);
    drive(16'd200, 1'b1);
    drive(16'd300, 1'b1);
    clear = 1'b1;
    drive(16'd250, 1'b1);
    clear = 1'b0;
    n_total += 3;
    if (busy !== 1'b0) $display("FAIL clear_busy: got %b want 0", busy); else n_pass++;
    if (trig_count !== exp_tc) $display("FAIL clear_trig_count: got %0d want %0d", trig_count, exp_tc); else n_pass++;
    if (peak_value !== 16'd300) $display("FAIL clear_peak_value: got %0d want 300", peak_value); else n_pass++;
    exp_trig(b + 11);
    for (int i = 0; i < 6; i++) drive(s[i], 1'b1);
    reset = 1'b0;
    drive(s[6], 1'b1);
    reset = 1'b1;
    exp_tc = '0;
    n_total += 3;
    if (busy !== 1'b0) $display("FAIL rst_abort_busy: got %b want 0", busy); else n_pass++;
    if (trig_count !== exp_tc) $display("FAIL rst_abort_trig_count: got %0d want %0d", trig_count, exp_tc); else n_pass++;
    if (peak_value !== 16'd0) $display("FAIL rst_abort_peak_value: got %0d want 0", peak_value); else n_pass++;
    for (int i = 0; i < 3; i++) drive(16'd250, 1'b1);
    n_total++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL abort_events: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL abort_ev: got e=%0d k=%b v=%0d t=%b want e=%0d k=%b v=%0d t=%b", o.e, o.k, o.v, o.t, e.e, e.k, e.v, e.t); else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset;
    test_pulse(1'b0);
    test_glitch;
    test_truncation;
    test_pulse(1'b1);
    test_abort;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
